// File: rtl/fft_pkg.sv
// Shared constants, sample type and arithmetic helpers for the FFT datapath.
// BUTTERFLY_SAT_EN selects clamping instead of wrapping in sat_or_wrap.
package fft_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned TW_W_DEF    = 16;
  localparam int unsigned TW_FRAC_DEF = 8;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] r;
    logic signed [DATA_W_DEF-1:0] i;
  } cplx_t;

  // Working width for intermediate arithmetic; wide enough for any legal config.
  localparam int unsigned WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t round_shift(input wide_t v, input int unsigned sh);
    wide_t half;
    if (sh == 0) return v;
    half = wide_t'(1) <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic out_of_range(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic wide_t sat_or_wrap(input wide_t v, input int unsigned w);
`ifdef BUTTERFLY_SAT_EN
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    // Keep the low w bits, sign-extended back to the working width.
    return (v <<< (WIDE_W - w)) >>> (WIDE_W - w);
`endif
  endfunction

endpackage

// File: rtl/butterfly_pipe_cmul.sv
// Two-stage complex multiply x*W (or x*conj(W)) with round-half-up to
// TW_FRAC fractional bits; advances only on the shared enable.
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TW_W    = TW_W_DEF,
  parameter int unsigned TW_FRAC = TW_FRAC_DEF
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   x_r,
  input  logic signed [DATA_W-1:0]   x_i,
  input  logic signed [TW_W-1:0]     w_r,
  input  logic signed [TW_W-1:0]     w_i,
  input  logic                       inv,
  output logic signed [DATA_W+TW_W:0] t_r,
  output logic signed [DATA_W+TW_W:0] t_i
);

  localparam int unsigned P_W = DATA_W + TW_W;
  localparam int unsigned T_W = P_W + 1;

  logic signed [TW_W:0]  wi_eff;
  logic signed [P_W-1:0] p_rr, p_ii, p_ri, p_ir;

  // One extra bit so that negating the most negative twiddle cannot wrap.
  always_comb begin
    wi_eff = (TW_W + 1)'(w_i);
    if (inv) wi_eff = -((TW_W + 1)'(w_i));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      p_rr <= P_W'(x_r) * P_W'(w_r);
      p_ii <= P_W'(x_i) * P_W'(wi_eff);
      p_ri <= P_W'(x_r) * P_W'(wi_eff);
      p_ir <= P_W'(x_i) * P_W'(w_r);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      t_r <= T_W'(round_shift(wide_t'(T_W'(p_rr) - T_W'(p_ii)), TW_FRAC));
      t_i <= T_W'(round_shift(wide_t'(T_W'(p_ri) + T_W'(p_ir)), TW_FRAC));
    end
  end

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: y1 = x1 + W*x2, y2 = x1 - W*x2, 3-cycle latency.
// Define BUTTERFLY_SAT_EN to clamp out-of-range results instead of wrapping.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TW_W    = TW_W_DEF,
  parameter int unsigned TW_FRAC = TW_FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x1_r,
  input  logic signed [DATA_W-1:0] x1_i,
  input  logic signed [DATA_W-1:0] x2_r,
  input  logic signed [DATA_W-1:0] x2_i,
  input  logic signed [TW_W-1:0]   w_r,
  input  logic signed [TW_W-1:0]   w_i,
  input  logic                     inv,
  input  logic                     scale,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y1_r,
  output logic signed [DATA_W-1:0] y1_i,
  output logic signed [DATA_W-1:0] y2_r,
  output logic signed [DATA_W-1:0] y2_i,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned T_W = DATA_W + TW_W + 1;

  logic en;
  logic v1, v2;
  logic signed [DATA_W-1:0] x1a_r, x1a_i, x1b_r, x1b_i;
  logic scale_a, scale_b;
  logic signed [T_W-1:0] t_r, t_i;
  wide_t sum [4];
  wide_t sc  [4];
  logic [3:0] oor;

  always_comb begin
    en       = !out_valid || out_ready;
    in_ready = en;
  end

  cmul_pipe #(
    .DATA_W  (DATA_W),
    .TW_W    (TW_W),
    .TW_FRAC (TW_FRAC)
  ) u_cmul (
    .clk (clk),
    .en  (en),
    .x_r (x2_r),
    .x_i (x2_i),
    .w_r (w_r),
    .w_i (w_i),
    .inv (inv),
    .t_r (t_r),
    .t_i (t_i)
  );

  // x1 and scale ride alongside the two multiplier stages.
  always_ff @(posedge clk) begin
    if (en) begin
      x1a_r   <= x1_r;
      x1a_i   <= x1_i;
      scale_a <= scale;
      x1b_r   <= x1a_r;
      x1b_i   <= x1a_i;
      scale_b <= scale_a;
    end
  end

  always_comb begin
    sum[0] = wide_t'(x1b_r) + wide_t'(t_r);
    sum[1] = wide_t'(x1b_i) + wide_t'(t_i);
    sum[2] = wide_t'(x1b_r) - wide_t'(t_r);
    sum[3] = wide_t'(x1b_i) - wide_t'(t_i);
    for (int unsigned k = 0; k < 4; k++) begin
      sc[k]  = scale_b ? ((sum[k] + wide_t'(1)) >>> 1) : sum[k];
      oor[k] = out_of_range(sc[k], DATA_W);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      y1_r      <= '0;
      y1_i      <= '0;
      y2_r      <= '0;
      y2_i      <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        y1_r <= DATA_W'(sat_or_wrap(sc[0], DATA_W));
        y1_i <= DATA_W'(sat_or_wrap(sc[1], DATA_W));
        y2_r <= DATA_W'(sat_or_wrap(sc[2], DATA_W));
        y2_i <= DATA_W'(sat_or_wrap(sc[3], DATA_W));
      end
    end
  end

  // A new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                  ovf <= 1'b0;
    else if (en && v2 && |oor)   ovf <= 1'b1;
    else if (ovf_clr)            ovf <= 1'b0;
  end

endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Pipelined, parametrised radix-2 DIT butterfly for the 8-point FFT datapath and its larger-N successors. It computes y1 = x1 + W·x2 and y2 = x1 − W·x2 on complex fixed-point samples with a fixed-point twiddle. It adds valid/ready flow control, forward/inverse mode, per-sample ÷2 scaling, round-half-up, saturation and a sticky overflow flag. It accepts one butterfly per cycle and sits between the twiddle ROM and the stage memory.

## Interface
- DATA_W, 16: width of each signed real/imag data component.
- TW_W, 16: width of each signed twiddle component.
- TW_FRAC, 8: fractional bits of the twiddle; 1.0 = 1<<TW_FRAC.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x1_r, x1_i, x2_r, x2_i  in  DATA_W each  signed operands.
- w_r, w_i  in  TW_W each  signed twiddle.
- inv  in  1  1 = use conj(W) (inverse FFT); sampled with the beat.
- scale  in  1  1 = halve both outputs (block scaling); sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y1_r, y1_i, y2_r, y2_i  out  DATA_W each  signed results.
- ovf  out  1  sticky: any result exceeded DATA_W range since reset/clear.
- ovf_clr  in  1  clears ovf on the next edge; a new overflow in the same cycle wins.

## Operation
- Beat transfers on in_valid & in_ready; output beat retires on out_valid & out_ready.
- Stage 1 (S1) registers four products x2_r·w_r, x2_i·w_i, x2_r·w_i' and x2_i·w_r, each DATA_W+TW_W bits. w_i' = −w_i when inv=1, else w_i. Negating −2^(TW_W−1) is done at TW_W+1 bits, with no wrap.
- Stage 2 (S2) forms t_r = p_rr − p_ii and t_i = p_ri + p_ir at DATA_W+TW_W+1 bits. It then rounds half-up: add 1<<(TW_FRAC−1), then arithmetic shift right by TW_FRAC. x1 and scale are delayed alongside.
- Stage 3 (S3) computes s1 = x1 + t and s2 = x1 − t at full width.
- If scale=1, S3 then computes s = (s+1)>>>1.
- Finally S3 range-checks each component against DATA_W and registers the outputs.
- ovf is set when any of the four components is out of range in a retiring S3 load.

## Timing
- Latency: 3 cycles from accepted beat to out_valid, with no stall.
- Throughput: 1 beat per cycle.
- Global enable: en = !out_valid | out_ready. in_ready = en. All stage registers and valid bits advance only when en=1.
- Bubbles do not collapse.
- When out_valid=1 and out_ready=0, all data outputs hold stable until accepted.
- Reset, while rst_n=0 at an edge:
  - all valid bits clear; out_valid=0.
  - y* = 0; ovf = 0.
  - in_ready = 1 after reset.
  - In-flight beats are discarded with no output.
- inv and scale are per-beat. Changing them between beats affects only later beats.

## Configuration
- BUTTERFLY_SAT_EN defined: out-of-range components clamp to +2^(DATA_W−1)−1 or −2^(DATA_W−1).
- BUTTERFLY_SAT_EN undefined: components wrap, keeping the low DATA_W bits.
- ovf detection and the sticky flag behave identically in both builds.

## Structure
- fft_pkg holds:
  - default DATA_W, TW_W and TW_FRAC constants;
  - a complex-sample typedef;
  - a round_shift function (round-half-up, arithmetic shift);
  - a sat_or_wrap function (guarded by BUTTERFLY_SAT_EN).
- One sub-module, cmul_pipe, covers S1–S2: the complex multiply with conjugate option, rounding and a 2-cycle latency, taking the shared enable.
- butterfly_pipe instantiates cmul_pipe and owns S3, flow control and ovf.

## Test plan
Default parameters, SAT build unless noted.
- **Real multiply:** x1=(100,0), x2=(50,0), w=(256,0), inv=0, scale=0 → after 3 cycles y1=(150,0), y2=(50,0), ovf=0.
- **Forward and inverse:**
  - Forward: w=(0,256), x1=(0,0), x2=(10,20), inv=0 → y1=(−20,10), y2=(20,−10).
  - Inverse: same beat with inv=1 → y1=(20,−10), y2=(−20,10).
- **Rounding:**
  - x2=(1,0), w=(128,0), x1=(0,0) → y1=(1,0), y2=(−1,0).
  - x2=(−1,0), same w and x1 → y1=(0,0).
- **Saturation and scaling:**
  - x1=x2=(32767,0), w=(256,0), scale=0 → y1_r=32767, y2_r=0, ovf=1 and sticky.
  - Wrap build: y1_r=−2.
  - scale=1: y1_r=32767 with no new overflow.
  - ovf_clr pulse → ovf=0.
- **Backpressure:**
  - Stimulus: stream 6 beats with out_ready=0 for cycles 4–8.
  - in_ready drops when out_valid=1 & out_ready=0.
  - Outputs stay stable.
  - All 6 results emerge in order with none lost or duplicated.
- **Reset mid-stream:**
  - Stimulus: assert rst_n=0 for 1 cycle with 3 beats in flight.
  - Following cycle: out_valid=0, y*=0, ovf=0, in_ready=1.
  - No stale beat emerges afterwards.
